// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues sequential word fetches, buffers in-order responses
// in a DEPTH-entry queue and hands {instr, pc, pc+4} to decode. Redirects flush everything.
module ifq_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_ent_t;

  logic [31:0]             fetch_pc, resp_pc;
  logic [CW-1:0]           count, outst, drop, outst_nxt;
  logic [CW:0]             credit_sum;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    issue, push, pop;
  logic [DEPTH-1:0]        slot_we;
  ifq_ent_t [DEPTH-1:0]    slot_q;
  ifq_ent_t                wr_ent, head;

  // Credit: queued + in-flight never exceeds DEPTH, so every response has a slot.
  assign credit_sum  = {1'b0, count} + {1'b0, outst};
  assign imem_req_o  = rst_i && (credit_sum < DEPTH_C) && !redirect_i;
  assign imem_addr_o = fetch_pc;
  assign issue       = imem_req_o && imem_gnt_i;
  assign push        = imem_rvalid_i && (drop == '0) && !redirect_i;
  assign pop         = valid_o && ready_i && !redirect_i;
  assign outst_nxt   = outst + CW'(issue) - CW'(imem_rvalid_i);

  assign wr_ent.instr = imem_rdata_i;
  assign wr_ent.pc    = resp_pc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect_i) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc <= redirect_pc_i;
        resp_pc  <= redirect_pc_i;
        count    <= '0;
        drop     <= outst_nxt;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (imem_rvalid_i && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push && (wr_ptr == AW'(i));
    ifq_slot #(.W($bits(ifq_ent_t))) u_slot (
      .clk   (clk_i),
      .rst_n (rst_i),
      .we    (slot_we[i]),
      .d     (wr_ent),
      .q     (slot_q[i])
    );
  end

  assign head       = slot_q[rd_ptr];
  assign valid_o    = (count != '0);
  assign instr_o    = valid_o ? head.instr : '0;
  assign pc_o       = valid_o ? head.pc : '0;
  assign pc_plus4_o = valid_o ? head.pc + 32'd4 : '0;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    push |-> ({1'b0, count} < DEPTH_C));
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_i)
    {1'b0, count} <= DEPTH_C);
  a_rvalid_owed: assert property (@(posedge clk_i) disable iff (!rst_i)
    imem_rvalid_i |-> (outst != '0));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed + randomized bench: memory model with in-order variable latency, scoreboard of issued pcs.
module tb_instr_fetch_queue;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o, pc_o, pc_plus4_o;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  int lat_fix = 1;
  bit rand_mode = 0;
  bit gnt_low = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hDEAD_BEEF) + {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (valid_o !== 1'b1 && k < 40) begin
      @(negedge clk_i); #1;
      k++;
    end
    chk(tag, {31'b0, valid_o}, 32'd1);
  endtask

  // Memory: decides gnt/rvalid mid-cycle, records each issue for the scoreboard.
  initial begin : mem_model
    int cyc = 0;
    int lat;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    forever begin
      @(negedge clk_i); #2;
      if (!rst_i) begin
        pend_q.delete(); exp_q.delete();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      end else begin
        imem_gnt_i = gnt_low ? 1'b0 : rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          imem_rvalid_i = 1'b0;
          imem_rdata_i  = '0;
        end
        #1;
        if (redirect_i) exp_q.delete();
        if (imem_req_o && imem_gnt_i) begin
          lat = rand_mode ? int'($urandom_range(1, 6)) : lat_fix;
          pend_q.push_back('{addr: imem_addr_o, due: cyc + lat});
          exp_q.push_back(imem_addr_o);
        end
      end
      cyc++;
    end
  end

  // Scoreboard: every pop must match the oldest surviving issued address.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk_i); #4;
      if (rst_i && valid_o && ready_i && !redirect_i) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          chk("sb_empty", pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", pc_o, e);
          chk("sb_instr", instr_o, mem_word(e));
          chk("sb_pc4", pc_plus4_o, e + 32'd4);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a0;
    int base;
    rst_i = 1'b0; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;

    // 1. reset state, first-valid latency, one instruction per cycle
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc4", pc_plus4_o, 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); #1;
    chk("t1_lat1", {31'b0, valid_o}, 32'd0);
    @(negedge clk_i); #1;
    chk("t1_lat2", {31'b0, valid_o}, 32'd1);
    chk("t1_pc0", pc_o, 32'h0);
    chk("t1_pc4", pc_plus4_o, 32'h4);
    repeat (8) begin
      @(negedge clk_i); #1;
      chk("t1_stream", {31'b0, valid_o}, 32'd1);
    end

    // 2. hold ready low from a fresh start: exactly four entries fill
    @(negedge clk_i); rst_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    #1;
    chk("t2_req_off", {31'b0, imem_req_o}, 32'd0);
    chk("t2_next_addr", imem_addr_o, 32'h10);
    chk("t2_head_pc", pc_o, 32'h0);
    chk("t2_head_instr", instr_o, mem_word(32'h0));
    repeat (3) @(negedge clk_i);
    #1;
    chk("t2_hold_pc", pc_o, 32'h0);
    base = n_pop;
    @(negedge clk_i); ready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    #1;
    chk("t2_drained", {31'b0, (n_pop - base) >= 5}, 32'd1);

    // 3. redirect with stale responses in flight and entries queued
    @(negedge clk_i); lat_fix = 3; ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    #1;
    chk("t3_noreq", {31'b0, imem_req_o}, 32'd0);
    @(negedge clk_i); redirect_i = 1'b0;
    #1;
    chk("t3_flushed", {31'b0, valid_o}, 32'd0);
    ready_i = 1'b1;
    wait_valid("t3_to");
    chk("t3_pc", pc_o, 32'h40);
    chk("t3_instr", instr_o, mem_word(32'h40));

    // 4. redirect colliding with a response and a pop; then back-to-back redirects
    @(negedge clk_i); lat_fix = 1;
    repeat (6) @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #3;
    chk("t4_pop_cycle", {31'b0, valid_o}, 32'd1);
    @(negedge clk_i); redirect_i = 1'b0;
    #1;
    wait_valid("t4_to");
    chk("t4_pc", pc_o, 32'h100);
    repeat (3) @(negedge clk_i);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    @(negedge clk_i); redirect_pc_i = 32'h300;
    @(negedge clk_i); redirect_i = 1'b0;
    #1;
    wait_valid("t4b_to");
    chk("t4b_pc", pc_o, 32'h300);
    chk("t4b_instr", instr_o, mem_word(32'h300));

    // 5. grant withheld: request and address hold steady
    @(negedge clk_i); gnt_low = 1'b1;
    #3;
    a0 = imem_addr_o;
    chk("t5_req0", {31'b0, imem_req_o}, 32'd1);
    repeat (4) begin
      @(negedge clk_i); #3;
      chk("t5_req", {31'b0, imem_req_o}, 32'd1);
      chk("t5_addr", imem_addr_o, a0);
    end
    @(negedge clk_i); gnt_low = 1'b0;
    #1;
    wait_valid("t5_to");
    chk("t5_resume", pc_o, a0);

    // random grant/latency/ready; scoreboard enforces a contiguous pc stream
    rand_mode = 1'b1;
    base = n_pop;
    repeat (300) begin
      @(negedge clk_i);
      ready_i = ($urandom_range(0, 3) != 0);
    end
    chk("t5_progress", {31'b0, (n_pop - base) >= 20}, 32'd1);

    // 6. asynchronous reset mid-burst
    @(negedge clk_i); ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1; rst_i = 1'b0;
    #1;
    chk("t6_valid", {31'b0, valid_o}, 32'd0);
    chk("t6_req", {31'b0, imem_req_o}, 32'd0);
    chk("t6_instr", instr_o, 32'd0);
    chk("t6_pc", pc_o, 32'd0);
    chk("t6_pc4", pc_plus4_o, 32'd0);
    rand_mode = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    wait_valid("t6_to");
    chk("t6_restart_pc", pc_o, 32'h0);
    repeat (6) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
